regfile_port_ctrl: RTL
======================

Name: regfile_port_ctrl

Overview:
- Initiator side of the Register_File read/write interface for the multi-cycle core.
- Accepts operand-fetch requests from decode over a valid/ready handshake and drives Rs/Rt. Samples read_value1/read_value2 and returns the operands to execute over a valid/ready handshake.
- Drives Rd/write_value/regwrite for writeback.
- Holds a busy scoreboard so reads never return a register whose pending producer has not yet written back.

Parameters:
DATA_W, 32, register data width
ADDR_W, 4, register index width; NREG = 2**ADDR_W registers

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
req_valid  in  1  decode presents operand-fetch request
req_ready  out  1  request accepted when req_valid & req_ready
req_rs  in  ADDR_W  source A index
req_rt  in  ADDR_W  source B index
req_rd  in  ADDR_W  destination marked busy on accept
req_rd_en  in  1  instruction will write req_rd
opnd_valid  out  1  opnd_a/opnd_b valid
opnd_ready  in  1  execute accepts operands
opnd_a  out  DATA_W  value of req_rs
opnd_b  out  DATA_W  value of req_rt
wb_valid  in  1  writeback request
wb_ready  out  1  writeback accepted
wb_rd  in  ADDR_W  writeback destination
wb_data  in  DATA_W  writeback value
Rs  out  ADDR_W  to Register_File
Rt  out  ADDR_W  to Register_File
Rd  out  ADDR_W  to Register_File
write_value  out  DATA_W  to Register_File
regwrite  out  1  to Register_File write enable
read_value1  in  DATA_W  from Register_File (combinational read of Rs)
read_value2  in  DATA_W  from Register_File (combinational read of Rt)

Behaviour:

Reset:
- state=IDLE, busy[] all 0, Rs=Rt=0, opnd_a=opnd_b=0, opnd_valid=0.
- Reset mid-operation abandons any in-flight request; the operand is never presented.

Register file contract:
- Reads are combinational.
- Write occurs at the rising edge when regwrite=1. R0 reads 0 and ignores writes.

Write path (combinational pass-through):
- wb_ready = ~reset.
- Rd = wb_rd, write_value = wb_data.
- regwrite = wb_valid & wb_ready & (wb_rd != 0). A wb to R0 completes its handshake with no write.

FSM IDLE -> READ -> HOLD -> IDLE:
- IDLE: req_ready = ~busy[req_rs] & ~busy[req_rt], evaluated from registered busy only. A same-cycle wb clearing busy does not unblock the request.
  - On accept: latch Rs<=req_rs, Rt<=req_rt, go READ.
  - If req_rd_en and req_rd != 0, set busy[req_rd].
- READ (one cycle): opnd_a <= read_value1, opnd_b <= read_value2, go HOLD.
  - Forwarding: if regwrite=1 this cycle and Rd==Rs (Rs != 0), opnd_a <= wb_data. Same for Rt/opnd_b.
- HOLD: opnd_valid=1. opnd_a/opnd_b stay stable until opnd_ready=1, then go IDLE.
  - req_ready=0 in READ and HOLD.

Latency:
- Request accepted at cycle N gives opnd_valid=1 at cycle N+2.
- Minimum request spacing is 3 cycles.

Scoreboard:
- An accepted wb clears busy[wb_rd].
- Same-cycle set (request accept) and clear (wb) of the same index: set wins.
- A wb to a non-busy register is legal: it writes and busy is unchanged.
- busy[0] is never set.

Decomposition:
- Package regfile_pkg:
  - FSM state enum (IDLE, READ, HOLD).
  - ZERO_REG = 0.
  - Default DATA_W/ADDR_W.
- Sub-module regfile_scoreboard (NREG busy bits; set/clear ports with set-wins priority; two combinational lookup ports).

Test Plan:
1. Write back R2=AAAA_BBBB and R3=CCCC_DDDD (regwrite pulses, one cycle each), then request rs=2/rt=3 -> opnd_valid two cycles after accept, opnd_a=AAAA_BBBB, opnd_b=CCCC_DDDD.
2. Request rs=1 rt=1 rd=4 rd_en=1, consume; next request rs=4 -> req_ready=0. wb R4=1234_5678 -> req_ready=1 the following cycle; opnd_a=1234_5678.
3. wb R5=9876_5432 in the exact READ cycle of a request with rs=5 -> opnd_a=9876_5432 (forwarded); Register_File also holds 9876_5432 afterwards.
4. wb R0=DEAD_BEEF -> regwrite=0, wb_ready=1; request rs=0 rt=2 -> opnd_a=0, opnd_b=AAAA_BBBB.
5. Hold opnd_ready=0 for 5 cycles in HOLD -> opnd_valid stays 1, operands stable, req_ready=0. Assert reset mid-HOLD -> next cycle opnd_valid=0, busy cleared, req_ready=1 for rs=4.
6. Same cycle: accept request with rd=6 rd_en=1 and wb to R6 -> busy[6] remains 1; a request with rs=6 stalls until the next wb to R6.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file port controller slice.
//   - state_e        : operand-fetch FSM states (IDLE, READ, HOLD)
//   - ZERO_REG       : index of the hard-wired zero register
//   - DEFAULT_DATA_W : default register data width
//   - DEFAULT_ADDR_W : default register index width (NREG = 2**ADDR_W)
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int ZERO_REG       = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register. A busy register has an issued
// producer that has not yet written back, so its value must not be read.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (clears all)
//   set_en, set_idx     : mark a destination busy (ignored for the zero reg)
//   clr_en, clr_idx     : writeback completed, clear busy
//   lkup_a_idx/_busy    : combinational lookup port A
//   lkup_b_idx/_busy    : combinational lookup port B
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic [ADDR_W-1:0] lkup_a_idx,
  output logic              lkup_a_busy,
  input  logic [ADDR_W-1:0] lkup_b_idx,
  output logic              lkup_b_busy
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Lookups read only the registered bits, so a writeback in the same
  // cycle never unblocks a request until the following cycle.
  assign lkup_a_busy = busy_q[lkup_a_idx];
  assign lkup_b_busy = busy_q[lkup_b_idx];

  // Next-state busy vector: the clear is applied first and the set second,
  // so a new producer issued in the same cycle as the old one's writeback
  // keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_idx] = 1'b0;
    end
    if (set_en && (set_idx != ADDR_W'(ZERO_REG))) begin
      busy_d[set_idx] = 1'b1;
    end
  end

  // Busy state register; reset abandons every outstanding producer.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_port_ctrl
// Initiator side of the Register_File read/write ports for the multi-cycle
// core. Fetches two operands per decode request and hands them to execute,
// while passing writebacks straight through to the register file.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   req_valid/req_ready              : decode operand-fetch handshake
//   req_rs, req_rt                   : source register indices
//   req_rd, req_rd_en                : destination marked busy on accept
//   opnd_valid/opnd_ready            : execute operand handshake
//   opnd_a, opnd_b                   : fetched operand values
//   wb_valid/wb_ready, wb_rd/wb_data : writeback request
//   Rs, Rt, Rd, write_value, regwrite: to Register_File
//   read_value1, read_value2         : from Register_File (combinational)
// ---------------------------------------------------------------------------
module regfile_port_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_rd_en,
  output logic              opnd_valid,
  input  logic              opnd_ready,
  output logic [DATA_W-1:0] opnd_a,
  output logic [DATA_W-1:0] opnd_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] Rs,
  output logic [ADDR_W-1:0] Rt,
  output logic [ADDR_W-1:0] Rd,
  output logic [DATA_W-1:0] write_value,
  output logic              regwrite,
  input  logic [DATA_W-1:0] read_value1,
  input  logic [DATA_W-1:0] read_value2
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs_q, rs_d;
  logic [ADDR_W-1:0] rt_q, rt_d;
  logic [DATA_W-1:0] opnd_a_q, opnd_a_d;
  logic [DATA_W-1:0] opnd_b_q, opnd_b_d;

  logic rs_busy;
  logic rt_busy;
  logic req_accept;
  logic busy_set;
  logic wb_accept;
  logic fwd_a;
  logic fwd_b;

  // Writeback is a pure pass-through; a write to the zero register still
  // completes its handshake but never raises the write enable.
  assign wb_ready    = ~reset;
  assign wb_accept   = wb_valid & wb_ready;
  assign Rd          = wb_rd;
  assign write_value = wb_data;
  assign regwrite    = wb_accept & (wb_rd != ADDR_W'(ZERO_REG));

  assign req_accept = req_valid & req_ready;
  assign busy_set   = req_accept & req_rd_en & (req_rd != ADDR_W'(ZERO_REG));

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .set_en      (busy_set),
    .set_idx     (req_rd),
    .clr_en      (wb_accept),
    .clr_idx     (wb_rd),
    .lkup_a_idx  (req_rs),
    .lkup_a_busy (rs_busy),
    .lkup_b_idx  (req_rt),
    .lkup_b_busy (rt_busy)
  );

  // The register file writes at the same edge we sample, so a matching
  // writeback must be forwarded. regwrite already excludes the zero
  // register, so a match here implies a nonzero source.
  assign fwd_a = regwrite & (wb_rd == rs_q);
  assign fwd_b = regwrite & (wb_rd == rt_q);

  // Next-state and handshake outputs for the fetch FSM.
  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    opnd_a_d  = opnd_a_q;
    opnd_b_d  = opnd_b_q;
    req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = ~reset & ~rs_busy & ~rt_busy;
        if (req_valid && req_ready) begin
          rs_d    = req_rs;
          rt_d    = req_rt;
          state_d = READ;
        end
      end
      READ: begin
        opnd_a_d = fwd_a ? wb_data : read_value1;
        opnd_b_d = fwd_b ? wb_data : read_value2;
        state_d  = HOLD;
      end
      HOLD: begin
        if (opnd_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operands are gated by reset so an abandoned fetch is never presented.
  assign opnd_valid = (state_q == HOLD) & ~reset;
  assign opnd_a     = opnd_a_q;
  assign opnd_b     = opnd_b_q;
  assign Rs         = rs_q;
  assign Rt         = rt_q;

  // FSM state, latched source indices and captured operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rs_q     <= '0;
      rt_q     <= '0;
      opnd_a_q <= '0;
      opnd_b_q <= '0;
    end else begin
      state_q  <= state_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      opnd_a_q <= opnd_a_d;
      opnd_b_q <= opnd_b_d;
    end
  end

endmodule
